// File: rtl/banner_renderer.sv
// Purpose: scaled bitmap banner that scrolls in from the right, then holds and optionally blinks.
// Latency: fixed 2 clocks from px_valid/px_x/px_y to pixel_valid/pixel_on.
// Backpressure: none; one pixel per clock is accepted and nothing ever stalls.
module banner_renderer #(
  parameter int GLYPH_W      = 16,
  parameter int GLYPH_H      = 16,
  parameter int MSG_COUNT    = 4,
  parameter int SCALE_LOG2   = 2,
  parameter int X_ORG        = 256,
  parameter int Y_ORG        = 208,
  parameter int SCREEN_W     = 640,
  parameter int SCROLL_STEP  = 8,
  parameter int BLINK_FRAMES = 30,
  parameter int MSG_W        = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1,
  // Bitmap image: word (msg*GLYPH_H + row) sits at [word*GLYPH_W +: GLYPH_W],
  // and bit GLYPH_W-1 of a word is the leftmost column.
  parameter logic [MSG_COUNT*GLYPH_H*GLYPH_W-1:0] ROM_IMAGE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic             px_valid,
  input  logic [9:0]       px_x,
  input  logic [9:0]       px_y,
  input  logic             show,
  input  logic [MSG_W-1:0] msg_sel,
  input  logic             blink_en,
  output logic             pixel_valid,
  output logic             pixel_on,
  output logic             busy,
  output logic             done
);

  localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
  localparam int IDX_W = MSG_W + ROW_W + 1;
  localparam int DEPTH = MSG_COUNT * GLYPH_H;
  localparam logic [10:0] BOX_W = 11'(GLYPH_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(GLYPH_H << SCALE_LOG2);

  typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

  state_t           state, state_nxt;
  logic [10:0]      cur_x, cur_x_nxt;
  logic [MSG_W-1:0] msg_q, msg_nxt;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_nxt;
  logic             phase, phase_nxt;
  logic             done_nxt;
  logic             show_q;

  // Control state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_x     <= 11'(SCREEN_W);
      msg_q     <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      done      <= 1'b0;
      show_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_x     <= cur_x_nxt;
      msg_q     <= msg_nxt;
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
      done      <= done_nxt;
      show_q    <= show;
    end
  end

  // Next state: dropping show wins over everything, including a frame_tick
  always_comb begin
    state_nxt     = state;
    cur_x_nxt     = cur_x;
    msg_nxt       = msg_q;
    blink_cnt_nxt = blink_cnt;
    phase_nxt     = phase;
    done_nxt      = 1'b0;
    if (!show) begin
      state_nxt     = IDLE;
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!show_q) begin
            state_nxt = SCROLL;
            msg_nxt   = msg_sel;
            cur_x_nxt = 11'(SCREEN_W);
          end
        end
        SCROLL: begin
          if (frame_tick) begin
            // Compare before subtracting so a small cur_x can never wrap
            if (cur_x <= 11'(X_ORG + SCROLL_STEP)) begin
              cur_x_nxt     = 11'(X_ORG);
              state_nxt     = HOLD;
              done_nxt      = 1'b1;
              blink_cnt_nxt = '0;
              phase_nxt     = 1'b1;
            end else begin
              cur_x_nxt = cur_x - 11'(SCROLL_STEP);
            end
          end
        end
        HOLD: begin
          if (!blink_en) begin
            blink_cnt_nxt = '0;
            phase_nxt     = 1'b1;
          end else if (frame_tick) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
              blink_cnt_nxt = '0;
              phase_nxt     = ~phase;
            end else begin
              blink_cnt_nxt = blink_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == SCROLL);

  // Stage 1 geometry, 11-bit two's complement offsets from the banner origin
  logic [10:0] rel_x, rel_y;
  logic        inbox, vis_now;
  assign rel_x   = {1'b0, px_x} - cur_x;
  assign rel_y   = {1'b0, px_y} - 11'(Y_ORG);
  assign inbox   = !rel_x[10] && !rel_y[10] && (rel_x < BOX_W) && (rel_y < BOX_H);
  // Clearing blink_en shows the banner on the very next pixel, not a frame later
  assign vis_now = (state != IDLE) && (phase || !blink_en);

  logic             s1_valid, s1_inbox, s1_vis;
  logic [COL_W-1:0] s1_col;
  logic [ROW_W-1:0] s1_row;
  logic [MSG_W-1:0] s1_msg;

  // Stage 1: freeze everything a pixel needs so later control changes cannot tear it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_inbox <= 1'b0;
      s1_vis   <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_msg   <= '0;
    end else begin
      s1_valid <= px_valid;
      s1_inbox <= inbox;
      s1_vis   <= vis_now;
      s1_col   <= rel_x[SCALE_LOG2 +: COL_W];
      s1_row   <= rel_y[SCALE_LOG2 +: ROW_W];
      s1_msg   <= msg_q;
    end
  end

  logic [IDX_W-1:0]   rom_idx;
  logic [GLYPH_W-1:0] rom_word;
  assign rom_idx = IDX_W'(s1_msg) * IDX_W'(GLYPH_H) + IDX_W'(s1_row);

  // Glyph lookup; indices past the last message read as blank
  always_comb begin
    rom_word = '0;
    if (rom_idx < IDX_W'(DEPTH)) begin
      rom_word = ROM_IMAGE[int'(rom_idx) * GLYPH_W +: GLYPH_W];
    end
  end

  // Stage 2: select the column bit and gate with the frozen qualifiers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid <= 1'b0;
      pixel_on    <= 1'b0;
    end else begin
      pixel_valid <= s1_valid;
      pixel_on    <= rom_word[COL_W'(GLYPH_W - 1) - s1_col] & s1_inbox & s1_vis & s1_valid;
    end
  end

endmodule

// File: tb/tb_banner_renderer.sv
// Purpose: directed plus randomized checking of banner_renderer against a geometric model.
// Latency: expects pixel results exactly 2 clocks after the pixel is presented.
// Backpressure: none; stimulus is driven one pixel per clock.
module tb_banner_renderer;

  // Message 3: every row has only its leftmost and rightmost column lit
  function automatic logic [1023:0] build_img();
    logic [1023:0] img;
    img = '0;
    for (int r = 0; r < 16; r++) img[(3 * 16 + r) * 16 +: 16] = 16'h8001;
    return img;
  endfunction
  localparam logic [1023:0] IMG = build_img();

  logic       clock = 1'b0;
  logic       reset_n, frame_tick, px_valid, show, blink_en;
  logic [9:0] px_x, px_y;
  logic [1:0] msg_sel;
  logic       pixel_valid, pixel_on, busy, done;

  int checks = 0;
  int failures = 0;
  logic hist [0:39];

  banner_renderer #(.ROM_IMAGE(IMG)) dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .px_valid(px_valid),
    .px_x(px_x), .px_y(px_y), .show(show), .msg_sel(msg_sel), .blink_en(blink_en),
    .pixel_valid(pixel_valid), .pixel_on(pixel_on), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Reference: banner at x=pos, y=208, 4x4 pixels per bit, 64x64 box
  function automatic logic model_pixel(input int x, input int y, input int pos,
                                       input int msg, input logic vis);
    int rx, ry, col;
    rx = x - pos;
    ry = y - 208;
    if (!vis || rx < 0 || ry < 0 || rx >= 64 || ry >= 64) return 1'b0;
    col = rx / 4;
    return (msg == 3) && (col == 0 || col == 15);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic exp);
    px_valid = 1'b1;
    px_x = 10'(x);
    px_y = 10'(y);
    step();
    px_valid = 1'b0;
    step();
    check({tag, "_valid"}, 32'(pixel_valid), 32'd1);
    check(tag, 32'(pixel_on), 32'(exp));
  endtask

  initial begin
    int x, y, pos;
    reset_n = 1'b1; frame_tick = 1'b0; px_valid = 1'b0; px_x = '0; px_y = '0;
    show = 1'b0; msg_sel = '0; blink_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_pixel_on", 32'(pixel_on), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    step();

    // Idle sweep: valid follows by two clocks, nothing lit
    for (int j = 0; j < 40; j++) begin
      hist[j] = 1'($urandom_range(0, 1));
      px_valid = hist[j];
      px_x = 10'($urandom_range(240, 340));
      px_y = 10'($urandom_range(200, 290));
      step();
      if (j >= 1) begin
        check("idle_valid_delay", 32'(pixel_valid), 32'(hist[j-1]));
        check("idle_pixel_off", 32'(pixel_on), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
      end
    end
    px_valid = 1'b0;
    step(); step();

    // Scroll in message 3; later msg_sel changes must be ignored
    show = 1'b1; msg_sel = 2'd3;
    step();
    msg_sel = 2'd1;
    probe("scroll_start", 640, 208, 1'b1);
    for (int k = 1; k <= 48; k++) begin
      tick();
      check("scroll_done", 32'(done), 32'(k == 48));
      check("scroll_busy", 32'(busy), 32'(k < 48));
      if (k == 1) begin
        probe("pos_tick1", 632, 208, 1'b1);
        probe("pos_tick1_left", 631, 208, 1'b0);
      end
      if (k == 20) begin
        pos = 640 - 8 * 20;
        for (int r = 0; r < 6; r++) begin
          x = $urandom_range(pos - 8, pos + 72);
          y = $urandom_range(200, 280);
          probe("scroll_rand", x, y, model_pixel(x, y, pos, 3, 1'b1));
        end
      end
      if (k == 47) probe("pos_tick47", 264, 208, 1'b1);
    end
    step();
    check("done_single_pulse", 32'(done), 32'd0);

    // Hold at X_ORG
    probe("hold_256_208", 256, 208, 1'b1);
    probe("hold_259_208", 259, 208, 1'b1);
    probe("hold_260_208", 260, 208, 1'b0);
    probe("hold_316_208", 316, 208, 1'b1);
    probe("hold_320_208", 320, 208, 1'b0);
    probe("hold_256_272", 256, 272, 1'b0);
    for (int r = 0; r < 20; r++) begin
      x = $urandom_range(240, 340);
      y = $urandom_range(200, 290);
      probe("hold_rand", x, y, model_pixel(x, y, 256, 3, 1'b1));
    end

    // Blink: 30 ticks per half period
    blink_en = 1'b1;
    for (int t = 1; t <= 90; t++) begin
      tick();
      probe("blink", 256, 208, ((t / 30) % 2) == 0);
    end
    blink_en = 1'b0;
    probe("blink_off_visible", 256, 208, 1'b1);

    // show drop coincident with the final scroll tick
    show = 1'b0;
    step();
    check("idle_after_drop", 32'(busy), 32'd0);
    show = 1'b1; msg_sel = 2'd3;
    step();
    for (int k = 1; k <= 47; k++) tick();
    check("busy_before_drop", 32'(busy), 32'd1);
    show = 1'b0; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("drop_no_done", 32'(done), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    step();
    check("drop_no_done_later", 32'(done), 32'd0);
    probe("drop_dark_256", 256, 208, 1'b0);
    probe("drop_dark_264", 264, 208, 1'b0);

    // Message 1 is blank
    show = 1'b1; msg_sel = 2'd1;
    step();
    check("msg1_busy", 32'(busy), 32'd1);
    probe("msg1_blank", 640, 208, 1'b0);

    // Asynchronous reset mid-scroll
    show = 1'b0;
    step();
    show = 1'b1; msg_sel = 2'd3;
    step();
    repeat (5) tick();
    px_valid = 1'b1; px_x = 10'd600; px_y = 10'd208;
    step(); step();
    check("prereset_pixel", 32'(pixel_on), 32'd1);
    check("prereset_busy", 32'(busy), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_pixel_on", 32'(pixel_on), 32'd0);
    check("async_pixel_valid", 32'(pixel_valid), 32'd0);
    show = 1'b0; px_valid = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    step();
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_cur_x", 32'(dut.cur_x), 32'd640);
    probe("post_reset_dark", 600, 208, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
